// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - EXE/MEM consumer: branch resolve, req/ack data-memory access, MEM/WB register
// Holds the upstream pipeline while a variable-latency memory access is outstanding.
module mem_wb_stage #(
   parameter int TIMEOUT = 255,
   parameter int CNT_W   = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] EXE_MEM_Result,
   input  logic [31:0] EXE_MEM_Rt,
   input  logic [31:0] EXE_MEM_BranchAddress,
   input  logic [4:0]  EXE_MEM_DstReg,
   input  logic        EXE_MEM_Zero,
   input  logic        EXE_MEM_BranchEqual,
   input  logic        EXE_MEM_BranchnotEqual,
   input  logic        EXE_MEM_MemRead,
   input  logic        EXE_MEM_MemWrite,
   input  logic        EXE_MEM_MemtoReg,
   input  logic        EXE_MEM_RegWrite,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        MEM_PCSrc,
   output logic [31:0] MEM_BranchTarget,
   output logic        MEM_Stall,
   output logic [31:0] MEM_WB_ReadData,
   output logic [31:0] MEM_WB_Result,
   output logic [4:0]  MEM_WB_DstReg,
   output logic        MEM_WB_MemtoReg,
   output logic        MEM_WB_RegWrite,
   output logic        mem_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             mem_op;
   logic             timed_out;

   assign mem_op    = EXE_MEM_MemRead | EXE_MEM_MemWrite;
   assign timed_out = (wait_cnt == LAST_CNT);

   assign MEM_PCSrc        = (EXE_MEM_BranchEqual & EXE_MEM_Zero) |
                             (EXE_MEM_BranchnotEqual & ~EXE_MEM_Zero);
   assign MEM_BranchTarget = EXE_MEM_BranchAddress;

   // Stall drops in the ack (or timeout) cycle so upstream advances on the same edge.
   always_comb begin
      MEM_Stall = 1'b0;
      case (state)
         S_IDLE:  MEM_Stall = mem_op;
         S_WAIT:  MEM_Stall = ~dmem_ack & ~timed_out;
         default: MEM_Stall = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= S_IDLE;
         wait_cnt        <= '0;
         dmem_req        <= 1'b0;
         dmem_we         <= 1'b0;
         dmem_addr       <= '0;
         dmem_wdata      <= '0;
         MEM_WB_ReadData <= '0;
         MEM_WB_Result   <= '0;
         MEM_WB_DstReg   <= '0;
         MEM_WB_MemtoReg <= 1'b0;
         MEM_WB_RegWrite <= 1'b0;
         mem_err         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (mem_op) begin
                  dmem_req        <= 1'b1;
                  dmem_we         <= EXE_MEM_MemWrite;
                  dmem_addr       <= {EXE_MEM_Result[31:2], 2'b00};
                  dmem_wdata      <= EXE_MEM_Rt;
                  wait_cnt        <= '0;
                  MEM_WB_RegWrite <= 1'b0;
                  state           <= S_WAIT;
               end else begin
                  MEM_WB_Result   <= EXE_MEM_Result;
                  MEM_WB_DstReg   <= EXE_MEM_DstReg;
                  MEM_WB_MemtoReg <= EXE_MEM_MemtoReg;
                  MEM_WB_RegWrite <= EXE_MEM_RegWrite;
               end
            end
            S_WAIT: begin
               if (dmem_ack) begin
                  MEM_WB_Result   <= EXE_MEM_Result;
                  MEM_WB_DstReg   <= EXE_MEM_DstReg;
                  MEM_WB_MemtoReg <= EXE_MEM_MemtoReg;
                  MEM_WB_RegWrite <= EXE_MEM_RegWrite;
                  if (!dmem_we)
                     MEM_WB_ReadData <= dmem_rdata;
                  dmem_req        <= 1'b0;
                  state           <= S_IDLE;
               end else if (timed_out) begin
                  // Abandoned access retires as a bubble; the error stays until reset.
                  dmem_req        <= 1'b0;
                  mem_err         <= 1'b1;
                  MEM_WB_RegWrite <= 1'b0;
                  state           <= S_IDLE;
               end else begin
                  wait_cnt        <= wait_cnt + CNT_W'(1);
                  MEM_WB_RegWrite <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - directed self-checking bench for mem_wb_stage
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] EXE_MEM_Result, EXE_MEM_Rt, EXE_MEM_BranchAddress;
   logic [4:0]  EXE_MEM_DstReg;
   logic        EXE_MEM_Zero, EXE_MEM_BranchEqual, EXE_MEM_BranchnotEqual;
   logic        EXE_MEM_MemRead, EXE_MEM_MemWrite, EXE_MEM_MemtoReg, EXE_MEM_RegWrite;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        MEM_PCSrc, MEM_Stall, MEM_WB_MemtoReg, MEM_WB_RegWrite, mem_err;
   logic [31:0] MEM_BranchTarget, MEM_WB_ReadData, MEM_WB_Result;
   logic [4:0]  MEM_WB_DstReg;

   int checks = 0;
   int errors = 0;
   int req_cycles;

   mem_wb_stage #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .EXE_MEM_Result(EXE_MEM_Result), .EXE_MEM_Rt(EXE_MEM_Rt),
      .EXE_MEM_BranchAddress(EXE_MEM_BranchAddress), .EXE_MEM_DstReg(EXE_MEM_DstReg),
      .EXE_MEM_Zero(EXE_MEM_Zero), .EXE_MEM_BranchEqual(EXE_MEM_BranchEqual),
      .EXE_MEM_BranchnotEqual(EXE_MEM_BranchnotEqual),
      .EXE_MEM_MemRead(EXE_MEM_MemRead), .EXE_MEM_MemWrite(EXE_MEM_MemWrite),
      .EXE_MEM_MemtoReg(EXE_MEM_MemtoReg), .EXE_MEM_RegWrite(EXE_MEM_RegWrite),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .MEM_PCSrc(MEM_PCSrc), .MEM_BranchTarget(MEM_BranchTarget), .MEM_Stall(MEM_Stall),
      .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_Result(MEM_WB_Result),
      .MEM_WB_DstReg(MEM_WB_DstReg), .MEM_WB_MemtoReg(MEM_WB_MemtoReg),
      .MEM_WB_RegWrite(MEM_WB_RegWrite), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      EXE_MEM_Result = '0; EXE_MEM_Rt = '0; EXE_MEM_BranchAddress = '0; EXE_MEM_DstReg = '0;
      EXE_MEM_Zero = 0; EXE_MEM_BranchEqual = 0; EXE_MEM_BranchnotEqual = 0;
      EXE_MEM_MemRead = 0; EXE_MEM_MemWrite = 0; EXE_MEM_MemtoReg = 0; EXE_MEM_RegWrite = 0;
      dmem_ack = 0; dmem_rdata = '0;
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      #12;
      check("rst_req", 32'(dmem_req), 0);
      check("rst_regwrite", 32'(MEM_WB_RegWrite), 0);
      check("rst_result", MEM_WB_Result, 0);
      check("rst_err", 32'(mem_err), 0);
      rst_n = 1'b1;
      tick();

      // ALU op flows through with latency 1
      EXE_MEM_RegWrite = 1; EXE_MEM_DstReg = 5; EXE_MEM_Result = 32'h1234;
      #1 check("alu_stall", 32'(MEM_Stall), 0);
      tick();
      check("alu_result", MEM_WB_Result, 32'h1234);
      check("alu_dst", 32'(MEM_WB_DstReg), 5);
      check("alu_regwrite", 32'(MEM_WB_RegWrite), 1);

      // Load at unaligned 0x103, acked in the fourth cycle
      clear_inputs();
      EXE_MEM_MemRead = 1; EXE_MEM_Result = 32'h103; EXE_MEM_RegWrite = 1;
      EXE_MEM_MemtoReg = 1; EXE_MEM_DstReg = 7;
      #1 check("ld_stall_idle", 32'(MEM_Stall), 1);
      tick();
      check("ld_req", 32'(dmem_req), 1);
      check("ld_addr", dmem_addr, 32'h100);
      check("ld_we", 32'(dmem_we), 0);
      check("ld_bubble0", 32'(MEM_WB_RegWrite), 0);
      check("ld_stall_w0", 32'(MEM_Stall), 1);
      tick();
      check("ld_bubble1", 32'(MEM_WB_RegWrite), 0);
      check("ld_stall_w1", 32'(MEM_Stall), 1);
      tick();
      dmem_ack = 1; dmem_rdata = 32'hDEADBEEF;
      #1 check("ld_stall_ack", 32'(MEM_Stall), 0);
      tick();
      clear_inputs();
      check("ld_rdata", MEM_WB_ReadData, 32'hDEADBEEF);
      check("ld_regwrite", 32'(MEM_WB_RegWrite), 1);
      check("ld_dst", 32'(MEM_WB_DstReg), 7);
      check("ld_req_drop", 32'(dmem_req), 0);

      // Store with both read and write set, immediate ack
      EXE_MEM_MemRead = 1; EXE_MEM_MemWrite = 1; EXE_MEM_Rt = 32'hA5A5A5A5;
      EXE_MEM_Result = 32'h200;
      tick();
      check("st_req", 32'(dmem_req), 1);
      check("st_we", 32'(dmem_we), 1);
      check("st_wdata", dmem_wdata, 32'hA5A5A5A5);
      dmem_ack = 1; dmem_rdata = 32'h11111111;
      #1 check("st_stall_ack", 32'(MEM_Stall), 0);
      tick();
      clear_inputs();
      check("st_req_drop", 32'(dmem_req), 0);
      check("st_rdata_hold", MEM_WB_ReadData, 32'hDEADBEEF);

      // Branch resolution and ack outside WAIT
      EXE_MEM_BranchEqual = 1; EXE_MEM_Zero = 1; EXE_MEM_BranchAddress = 32'h400;
      dmem_ack = 1; dmem_rdata = 32'h22222222;
      #1;
      check("beq_taken", 32'(MEM_PCSrc), 1);
      check("beq_target", MEM_BranchTarget, 32'h400);
      check("beq_stall", 32'(MEM_Stall), 0);
      EXE_MEM_BranchEqual = 0; EXE_MEM_BranchnotEqual = 1;
      #1 check("bne_zero", 32'(MEM_PCSrc), 0);
      EXE_MEM_Zero = 0;
      #1 check("bne_nonzero", 32'(MEM_PCSrc), 1);
      tick();
      check("idle_ack_ignored", MEM_WB_ReadData, 32'hDEADBEEF);
      clear_inputs();

      // Timeout with TIMEOUT=4: request held 4 cycles, then aborted
      EXE_MEM_MemRead = 1; EXE_MEM_RegWrite = 1; EXE_MEM_Result = 32'h300;
      req_cycles = 0;
      tick();
      for (int i = 0; i < 10 && dmem_req; i++) begin
         req_cycles++;
         tick();
      end
      clear_inputs();
      check("to_req_cycles", 32'(req_cycles), 4);
      check("to_req_drop", 32'(dmem_req), 0);
      check("to_err", 32'(mem_err), 1);
      check("to_bubble", 32'(MEM_WB_RegWrite), 0);
      EXE_MEM_RegWrite = 1; EXE_MEM_DstReg = 9; EXE_MEM_Result = 32'h55;
      tick();
      check("to_next_regwrite", 32'(MEM_WB_RegWrite), 1);
      check("to_next_dst", 32'(MEM_WB_DstReg), 9);
      check("to_err_sticky", 32'(mem_err), 1);
      clear_inputs();

      // Asynchronous reset in the middle of WAIT
      EXE_MEM_MemRead = 1; EXE_MEM_RegWrite = 1; EXE_MEM_Result = 32'h500;
      tick();
      check("rw_req", 32'(dmem_req), 1);
      #2 rst_n = 1'b0;
      #1;
      check("rw_req_drop", 32'(dmem_req), 0);
      check("rw_result", MEM_WB_Result, 0);
      check("rw_dst", 32'(MEM_WB_DstReg), 0);
      check("rw_err", 32'(mem_err), 0);
      clear_inputs();
      #1 rst_n = 1'b1;
      tick();
      dmem_ack = 1; dmem_rdata = 32'h33333333;
      tick();
      dmem_ack = 0;
      check("rw_late_ack", MEM_WB_ReadData, 0);
      check("rw_late_req", 32'(dmem_req), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
